multi_switch_event_fsm: RTL and testbench

- Multi-channel successor to the single-switch on/off detector used for FIFO push/pop control.
- Each channel does three things:
  - synchronises a raw switch/button input;
  - debounces it with a programmable stable-cycle count;
  - emits one-cycle rise/fall pulses, with optional auto-repeat while the input is held.
- Sits between board switches and FIFO/control logic. It replaces per-switch instances of the simple detector.

---
 rtl/multi_switch_event_fsm_pkg.sv | 28 ++
 rtl/multi_switch_event_fsm_chan.sv | 151 +++++++++++++++
 rtl/multi_switch_event_fsm.sv | 96 +++++++++
 tb/tb_multi_switch_event_fsm.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_switch_event_fsm_pkg.sv
// -----------------------------------------------------------------------------
// multi_switch_event_fsm_pkg
//   Shared definitions for the multi-channel switch event detector:
//   per-channel FSM state encoding, evt source selection codes and a small
//   helper that decodes the debounced level from a channel state.
// -----------------------------------------------------------------------------
package multi_switch_event_fsm_pkg;

    // Per-channel debounce FSM. Bit 1 of the encoding is the debounced level:
    // ON and FALL_WAIT both report 1 because a release is only tentative
    // until the debounce completes.
    typedef enum logic [1:0] {
        ST_OFF       = 2'b00,
        ST_RISE_WAIT = 2'b01,
        ST_ON        = 2'b10,
        ST_FALL_WAIT = 2'b11
    } sw_state_e;

    // evt source selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic logic state_level(input sw_state_e st);
        return st[1];
    endfunction

endpackage

// File: rtl/multi_switch_event_fsm_chan.sv
// -----------------------------------------------------------------------------
// multi_switch_event_fsm_chan
//   One switch channel: 2-flop synchroniser, debounce FSM with stable-cycle
//   counter, and auto-repeat timer. Produces the stage-0 (pre-output-register)
//   level and one-cycle rise/fall/repeat flags; the top registers them.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset (clears synchroniser too)
//   clr       in   synchronous clear of FSM, counters and flags (not the
//                  synchroniser)
//   sw_raw    in   raw asynchronous switch input
//   level_p0  out  debounced level decoded from the current state
//   rise_p0   out  registered flag: accepted 0->1 transition this cycle
//   fall_p0   out  registered flag: accepted 1->0 transition this cycle
//   rpt_p0    out  registered flag: auto-repeat period elapsed while ON
// -----------------------------------------------------------------------------
module multi_switch_event_fsm_chan
    import multi_switch_event_fsm_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic sw_raw,
    output logic level_p0,
    output logic rise_p0,
    output logic fall_p0,
    output logic rpt_p0
);

    localparam int DB_W = $clog2(DB_CYCLES) + 1;
    // Keep the repeat counter at a legal width even when repeat is disabled.
    localparam int RPT_N = (REPEAT_CYCLES > 1) ? REPEAT_CYCLES : 2;
    localparam int RPT_W = $clog2(RPT_N) + 1;
    localparam bit RPT_EN = (REPEAT_CYCLES > 0);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_N - 1);

    logic             sync_q1;
    logic             sync_q2;
    sw_state_e        state;
    sw_state_e        state_nxt;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_cnt_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             rpt_nxt;

    // ---- synchroniser: the FSM only ever looks at sync_q2 ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
        end
    end

    // ---- state register: FSM, counters and stage-0 pulse flags ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_OFF;
            db_cnt  <= '0;
            rpt_cnt <= '0;
            rise_p0 <= 1'b0;
            fall_p0 <= 1'b0;
            rpt_p0  <= 1'b0;
        end else if (clr) begin
            // clr wins over any transition; a pending release is dropped
            // silently rather than reported as a fall.
            state   <= ST_OFF;
            db_cnt  <= '0;
            rpt_cnt <= '0;
            rise_p0 <= 1'b0;
            fall_p0 <= 1'b0;
            rpt_p0  <= 1'b0;
        end else begin
            state   <= state_nxt;
            db_cnt  <= db_cnt_nxt;
            rpt_cnt <= rpt_cnt_nxt;
            rise_p0 <= rise_nxt;
            fall_p0 <= fall_nxt;
            rpt_p0  <= rpt_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt   = state;
        db_cnt_nxt  = db_cnt;
        rpt_cnt_nxt = rpt_cnt;
        unique case (state)
            ST_OFF: begin
                if (sync_q2) begin
                    state_nxt  = ST_RISE_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            ST_RISE_WAIT: begin
                if (!sync_q2) begin
                    state_nxt = ST_OFF;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt   = ST_ON;
                    rpt_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            ST_ON: begin
                // The repeat timer runs on every ON cycle, including the one
                // where a release starts; FALL_WAIT then freezes it so a
                // rejected glitch resumes the period where it left off.
                if (RPT_EN) begin
                    rpt_cnt_nxt = (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + RPT_W'(1);
                end
                if (!sync_q2) begin
                    state_nxt  = ST_FALL_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            ST_FALL_WAIT: begin
                if (sync_q2) begin
                    state_nxt = ST_ON;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = ST_OFF;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase
    end

    // ---- output decode ----
    always_comb begin
        level_p0 = state_level(state);
        rise_nxt = (state == ST_RISE_WAIT) && sync_q2 && (db_cnt == DB_LAST);
        fall_nxt = (state == ST_FALL_WAIT) && !sync_q2 && (db_cnt == DB_LAST);
        rpt_nxt  = RPT_EN && (state == ST_ON) && (rpt_cnt == RPT_LAST);
    end

endmodule

// File: rtl/multi_switch_event_fsm.sv
// -----------------------------------------------------------------------------
// multi_switch_event_fsm
//   N_CH independent debounced switch channels with one-cycle rise/fall
//   pulses and an evt pulse built from the selected edge(s) plus optional
//   auto-repeat while a switch is held.
//
// Parameters:
//   N_CH           number of channels (1..32)
//   DB_CYCLES      stable-cycle count to accept a level change (>=1)
//   EDGE_MODE      evt source: EDGE_RISE, EDGE_FALL or EDGE_BOTH
//   REPEAT_CYCLES  auto-repeat period while held ON; 0 disables (else >=2)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear: all channels to OFF, no pulses
//   sw_in    in   raw asynchronous switch inputs [N_CH]
//   level    out  debounced level per channel (registered)
//   rise     out  one-cycle pulse on accepted 0->1 (registered)
//   fall     out  one-cycle pulse on accepted 1->0 (registered)
//   evt      out  selected edge pulse ORed with repeat pulse (registered)
// -----------------------------------------------------------------------------
module multi_switch_event_fsm
    import multi_switch_event_fsm_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 4,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] evt
);

    logic [N_CH-1:0] level_p0;
    logic [N_CH-1:0] rise_p0;
    logic [N_CH-1:0] fall_p0;
    logic [N_CH-1:0] rpt_p0;
    logic [N_CH-1:0] edge_sel_p0;

    // ---- stage 0: per-channel synchroniser + debounce FSM ----
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
        multi_switch_event_fsm_chan #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .clr      (clr),
            .sw_raw   (sw_in[ch]),
            .level_p0 (level_p0[ch]),
            .rise_p0  (rise_p0[ch]),
            .fall_p0  (fall_p0[ch]),
            .rpt_p0   (rpt_p0[ch])
        );
    end

    always_comb begin
        edge_sel_p0 = rise_p0;
        if (EDGE_MODE == EDGE_FALL) begin
            edge_sel_p0 = fall_p0;
        end else if (EDGE_MODE == EDGE_BOTH) begin
            edge_sel_p0 = rise_p0 | fall_p0;
        end
    end

    // ---- stage 1: output registers ----
    // Registering level from the state keeps level and the edge pulses
    // changing on the same clock edge. clr also empties this stage so a
    // pulse already in flight never escapes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            evt   <= '0;
        end else if (clr) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            evt   <= '0;
        end else begin
            level <= level_p0;
            rise  <= rise_p0;
            fall  <= fall_p0;
            evt   <= edge_sel_p0 | rpt_p0;
        end
    end

endmodule

// File: tb/tb_multi_switch_event_fsm.sv
// -----------------------------------------------------------------------------
// tb_multi_switch_event_fsm
//   Three copies of the detector share one stimulus: rise-only evt without
//   repeat, both-edge evt with an 8-cycle repeat, and fall-only evt. A
//   run-length reference model predicts every output of all three copies.
// -----------------------------------------------------------------------------
module tb_multi_switch_event_fsm;

    localparam int N   = 4;
    localparam int DB  = 4;
    localparam int RPT = 8;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         clr     = 1'b0;
    logic [N-1:0] sw_in   = '0;

    logic [N-1:0] lvl_a, rise_a, fall_a, evt_a;
    logic [N-1:0] lvl_b, rise_b, fall_b, evt_b;
    logic [N-1:0] lvl_c, rise_c, fall_c, evt_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_switch_event_fsm #(.N_CH(N), .DB_CYCLES(DB), .EDGE_MODE(0), .REPEAT_CYCLES(0)) u_dut_rise (
        .clk(clk), .reset_n(reset_n), .clr(clr), .sw_in(sw_in),
        .level(lvl_a), .rise(rise_a), .fall(fall_a), .evt(evt_a));

    multi_switch_event_fsm #(.N_CH(N), .DB_CYCLES(DB), .EDGE_MODE(2), .REPEAT_CYCLES(RPT)) u_dut_both (
        .clk(clk), .reset_n(reset_n), .clr(clr), .sw_in(sw_in),
        .level(lvl_b), .rise(rise_b), .fall(fall_b), .evt(evt_b));

    multi_switch_event_fsm #(.N_CH(N), .DB_CYCLES(DB), .EDGE_MODE(1), .REPEAT_CYCLES(0)) u_dut_fall (
        .clk(clk), .reset_n(reset_n), .clr(clr), .sw_in(sw_in),
        .level(lvl_c), .rise(rise_c), .fall(fall_c), .evt(evt_c));

    // ---------------- reference model ----------------
    // acc: accepted level; run: consecutive synchronised samples disagreeing
    // with acc (a change is accepted on the DB+1-th); rc: cycles spent held
    // since the last rise/repeat.
    typedef struct packed {
        logic acc;
        int   run;
        int   rc;
        logic pr;
        logic pf;
        logic pp;
    } ch_m_t;

    ch_m_t        m_ch[N];
    logic [N-1:0] m_s1 = '0, m_s2 = '0;
    logic [N-1:0] o_lvl = '0, o_r = '0, o_f = '0, o_p = '0;

    function automatic ch_m_t chan_next(input logic s, input ch_m_t cur, input logic clr_i);
        ch_m_t n;
        n    = cur;
        n.pr = 1'b0;
        n.pf = 1'b0;
        n.pp = 1'b0;
        if (clr_i) begin
            n.acc = 1'b0;
            n.run = 0;
            n.rc  = 0;
        end else begin
            if (cur.acc && cur.run == 0) begin
                if (cur.rc == RPT - 1) begin
                    n.pp = 1'b1;
                    n.rc = 0;
                end else begin
                    n.rc = cur.rc + 1;
                end
            end
            if (s != cur.acc) begin
                n.run = cur.run + 1;
                if (n.run == DB + 1) begin
                    n.acc = ~cur.acc;
                    n.run = 0;
                    if (n.acc) begin
                        n.pr = 1'b1;
                        n.rc = 0;
                    end else begin
                        n.pf = 1'b1;
                    end
                end
            end else begin
                n.run = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1  <= '0;
            m_s2  <= '0;
            o_lvl <= '0;
            o_r   <= '0;
            o_f   <= '0;
            o_p   <= '0;
            for (int i = 0; i < N; i++) m_ch[i] <= '0;
        end else begin
            m_s1 <= sw_in;
            m_s2 <= m_s1;
            for (int i = 0; i < N; i++) begin
                o_lvl[i] <= clr ? 1'b0 : m_ch[i].acc;
                o_r[i]   <= clr ? 1'b0 : m_ch[i].pr;
                o_f[i]   <= clr ? 1'b0 : m_ch[i].pf;
                o_p[i]   <= clr ? 1'b0 : m_ch[i].pp;
                m_ch[i]  <= chan_next(m_s2[i], m_ch[i], clr);
            end
        end
    end

    logic [12*N-1:0] obs, exp_v;
    assign obs   = {lvl_a, rise_a, fall_a, evt_a, lvl_b, rise_b, fall_b, evt_b,
                    lvl_c, rise_c, fall_c, evt_c};
    assign exp_v = {o_lvl, o_r, o_f, o_r, o_lvl, o_r, o_f, o_r | o_f | o_p,
                    o_lvl, o_r, o_f, o_f};

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        sw_in   = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_hold obs=%h exp=0", obs);
        end
        sw_in = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        sw_in[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL press_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
            checks++;
            if (rise_a[0] !== (k == 7) || evt_a[0] !== (k == 7) || lvl_a[0] !== (k >= 7)) begin
                errors++;
                $display("FAIL press_ch0 k=%0d lvl=%b rise=%b evt=%b exp_pulse=%b", k, lvl_a[0], rise_a[0], evt_a[0], k == 7);
            end
            checks++;
            if (lvl_a[3:1] !== 3'b000 || rise_a[3:1] !== 3'b000) begin
                errors++;
                $display("FAIL press_others k=%0d lvl=%b rise=%b exp=000", k, lvl_a[3:1], rise_a[3:1]);
            end
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 20; c++) begin
            sw_in[1] = (c % 4 != 3);
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce_model c=%0d obs=%h exp=%h", c, obs, exp_v);
            end
            checks++;
            if (rise_a[1] !== 1'b0 || lvl_a[1] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_ch1 c=%0d lvl=%b rise=%b exp=0", c, lvl_a[1], rise_a[1]);
            end
        end
        sw_in[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL settle_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
            checks++;
            if (rise_a[1] !== (k == 7) || lvl_a[1] !== (k >= 7)) begin
                errors++;
                $display("FAIL settle_ch1 k=%0d lvl=%b rise=%b exp_pulse=%b", k, lvl_a[1], rise_a[1], k == 7);
            end
        end
    endtask

    task automatic test_release();
        // two-cycle low glitch while ON must not release
        for (int k = 0; k < 12; k++) begin
            sw_in[0] = (k >= 2);
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL glitch_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
            checks++;
            if (fall_b[0] !== 1'b0 || lvl_b[0] !== 1'b1) begin
                errors++;
                $display("FAIL glitch_ch0 k=%0d lvl=%b fall=%b exp lvl=1 fall=0", k, lvl_b[0], fall_b[0]);
            end
        end
        sw_in[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL release_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
            checks++;
            if (fall_b[0] !== (k == 7) || evt_c[0] !== (k == 7) || evt_a[0] !== 1'b0 || lvl_b[0] !== (k < 7)) begin
                errors++;
                $display("FAIL release_ch0 k=%0d lvl=%b fall=%b evt_fall=%b evt_rise=%b exp_pulse=%b",
                         k, lvl_b[0], fall_b[0], evt_c[0], evt_a[0], k == 7);
            end
            if (k == 7) begin
                checks++;
                if (evt_b[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL release_evt_both obs=%b exp=1", evt_b[0]);
                end
            end
        end
    endtask

    task automatic test_repeat();
        int rises = 0;
        sw_in[2] = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            rises += int'(rise_b[2]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL repeat_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
            checks++;
            if (evt_b[2] !== ((k >= 7) && ((k - 7) % RPT == 0)) || evt_a[2] !== (k == 7)) begin
                errors++;
                $display("FAIL repeat_ch2 k=%0d evt_both=%b evt_rise=%b exp_both=%b", k, evt_b[2], evt_a[2],
                         (k >= 7) && ((k - 7) % RPT == 0));
            end
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL repeat_rise_count got=%0d exp=1", rises);
        end
        sw_in[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL repeat_release k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_clr();
        int rises = 0;
        int falls = 0;
        sw_in[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clr_press k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL clr_outputs obs=%h exp=0", obs);
        end
        for (int k = 1; k < 14; k++) begin
            @(negedge clk);
            rises += int'(rise_a[3]);
            falls += int'(fall_a[3]) + int'(fall_b[3]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clr_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
        end
        checks++;
        if (rises != 1 || falls != 0) begin
            errors++;
            $display("FAIL clr_rerise rises=%0d falls=%0d exp rises=1 falls=0", rises, falls);
        end
    endtask

    task automatic test_reset_mid();
        sw_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rstmid_press k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rstmid_async obs=%h exp=0", obs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rstmid_model k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
            checks++;
            if (rise_a !== ((k == 7) ? 4'b1011 : 4'b0000)) begin
                errors++;
                $display("FAIL rstmid_rise k=%0d obs=%b exp=%b", k, rise_a, (k == 7) ? 4'b1011 : 4'b0000);
            end
        end
    endtask

    task automatic test_simultaneous();
        sw_in = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL simul_idle k=%0d obs=%h exp=%h", k, obs, exp_v);
            end
        end
        sw_in = '1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (rise_a !== ((k == 7) ? 4'b1111 : 4'b0000) || evt_c !== 4'b0000) begin
                errors++;
                $display("FAIL simul_press k=%0d rise=%b evt_fall=%b", k, rise_a, evt_c);
            end
        end
        sw_in = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (fall_a !== ((k == 7) ? 4'b1111 : 4'b0000) || evt_c !== fall_a || evt_a !== 4'b0000) begin
                errors++;
                $display("FAIL simul_release k=%0d fall=%b evt_fall=%b evt_rise=%b", k, fall_a, evt_c, evt_a);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int unsigned span;
            span = (((c / 100) % 2) == 1) ? 14 : 2;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(span, 0) == 0) sw_in[i] = ~sw_in[i];
            end
            clr = ($urandom_range(79, 0) == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_model c=%0d obs=%h exp=%h", c, obs, exp_v);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_repeat();
        test_clr();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
